// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// Decode-to-execute pipeline stage. Buffers one decoded instruction in a
// single slot and presents resolved operands to the main ALU.
//
// Features:
//   - valid/ready handshake on the decode side and on the execute side
//   - MEM/WB bypass at capture time, and MEM/WB snooping while the slot waits
//   - EX/MEM and MEM/WB operand forwarding (optional)
//   - bubble insertion on hazards
//   - flush on branch redirect
//
// Configuration macro: ID_EX_FORWARDING_EN
//   defined   : combinational EX/MEM > MEM/WB > stored operand forwarding.
//               Only a load in EX/MEM that feeds a used source stalls.
//   undefined : the operands are the stored values only. Any in-flight
//               producer write to a used source stalls the slot until both
//               producers are clear. Snoop and capture bypass still refresh
//               the stored values.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_*                 decode-side instruction offer (id_valid/id_ready)
//   flush                kills the buffered instruction and any capture
//   exmem_*              EX/MEM producer (rd, reg_write, mem_read, result)
//   memwb_*              MEM/WB producer (rd, reg_write, result)
//   ex_valid / ex_ready  execute-side handshake
//   ex_op1, ex_op2       ALU operands (op2 = immediate when use_imm)
//   ex_store_data        resolved rs2 for stores
//   ex_pc, ex_alu_op, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
//                        buffered instruction fields
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    // decode side
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic [RIDX-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    // redirect
    input  logic            flush,
    // EX/MEM producer
    input  logic [RIDX-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic            exmem_mem_read,
    input  logic [XLEN-1:0] exmem_result,
    // MEM/WB producer
    input  logic [RIDX-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    // execute side
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      ex_alu_op,
    output logic [RIDX-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    // A producer write hits a source register; x0 never matches.
    function automatic logic src_match(
        input logic            wr,
        input logic [RIDX-1:0] prod_rd,
        input logic [RIDX-1:0] src
    );
        return wr && (prod_rd == src) && (src != {RIDX{1'b0}});
    endfunction

    // ---------------------------------------------------------------------
    // Slot storage
    // ---------------------------------------------------------------------
    logic            slot_valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imm_r;
    logic [XLEN-1:0] rs1_val_r;
    logic [XLEN-1:0] rs2_val_r;
    logic [RIDX-1:0] rs1_r;
    logic [RIDX-1:0] rs2_r;
    logic [RIDX-1:0] rd_r;
    logic [3:0]      alu_op_r;
    logic            use_imm_r;
    logic            reg_write_r;
    logic            mem_read_r;
    logic            mem_write_r;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    logic            advance_s;
    logic            capture_s;
    logic            hazard_s;
    logic            rs2_used_s;
    logic [XLEN-1:0] rs1_res_s;
    logic [XLEN-1:0] rs2_res_s;
    logic [XLEN-1:0] cap_rs1_s;
    logic [XLEN-1:0] cap_rs2_s;

    assign ex_valid  = slot_valid_r && !hazard_s;
    assign advance_s = ex_valid && ex_ready;
    assign id_ready  = !slot_valid_r || advance_s;
    // id_ready is not gated by flush; flush is a kill that decode honours.
    assign capture_s = id_valid && id_ready && !flush;

    // rs2 is a real source unless the immediate replaces it on a non-store.
    assign rs2_used_s = !use_imm_r || mem_write_r;

    // Capture-time bypass of a register file that has not yet seen MEM/WB.
    always_comb begin
        cap_rs1_s = id_rs1_data;
        cap_rs2_s = id_rs2_data;
        if (src_match(memwb_reg_write, memwb_rd, id_rs1)) begin
            cap_rs1_s = memwb_result;
        end else begin
            cap_rs1_s = id_rs1_data;
        end
        if (src_match(memwb_reg_write, memwb_rd, id_rs2)) begin
            cap_rs2_s = memwb_result;
        end else begin
            cap_rs2_s = id_rs2_data;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // Operand forwarding (EX/MEM over MEM/WB over stored) and load-use detection.
    always_comb begin
        rs1_res_s = rs1_val_r;
        rs2_res_s = rs2_val_r;
        hazard_s  = 1'b0;
        // A load in EX/MEM has no data yet, so it is never a forwarding source.
        if (src_match(exmem_reg_write && !exmem_mem_read, exmem_rd, rs1_r)) begin
            rs1_res_s = exmem_result;
        end else if (src_match(memwb_reg_write, memwb_rd, rs1_r)) begin
            rs1_res_s = memwb_result;
        end else begin
            rs1_res_s = rs1_val_r;
        end
        if (src_match(exmem_reg_write && !exmem_mem_read, exmem_rd, rs2_r)) begin
            rs2_res_s = exmem_result;
        end else if (src_match(memwb_reg_write, memwb_rd, rs2_r)) begin
            rs2_res_s = memwb_result;
        end else begin
            rs2_res_s = rs2_val_r;
        end
        if (slot_valid_r && exmem_mem_read &&
            (src_match(exmem_reg_write, exmem_rd, rs1_r) ||
             (rs2_used_s && src_match(exmem_reg_write, exmem_rd, rs2_r)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end
`else
    // EX/MEM data has no consumer when operands come only from the slot.
    logic unused_exmem_s;
    assign unused_exmem_s = ^exmem_result;

    // Stored operands only; stall on any pending producer write to a used source.
    always_comb begin
        rs1_res_s = rs1_val_r;
        rs2_res_s = rs2_val_r;
        hazard_s  = 1'b0;
        if (slot_valid_r &&
            (src_match(exmem_reg_write, exmem_rd, rs1_r) ||
             src_match(memwb_reg_write, memwb_rd, rs1_r) ||
             (rs2_used_s &&
              (src_match(exmem_reg_write, exmem_rd, rs2_r) ||
               src_match(memwb_reg_write, memwb_rd, rs2_r))))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------

    // Slot occupancy: flush wins, then capture, then drain on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 1'b0;
        end else if (flush) begin
            slot_valid_r <= 1'b0;
        end else if (capture_s) begin
            slot_valid_r <= 1'b1;
        end else if (advance_s) begin
            slot_valid_r <= 1'b0;
        end else begin
            slot_valid_r <= slot_valid_r;
        end
    end

    // Slot fields: load on capture, otherwise snoop MEM/WB while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            rs1_val_r   <= {XLEN{1'b0}};
            rs2_val_r   <= {XLEN{1'b0}};
            rs1_r       <= {RIDX{1'b0}};
            rs2_r       <= {RIDX{1'b0}};
            rd_r        <= {RIDX{1'b0}};
            alu_op_r    <= 4'h0;
            use_imm_r   <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (capture_s) begin
            pc_r        <= id_pc;
            imm_r       <= id_imm;
            rs1_val_r   <= cap_rs1_s;
            rs2_val_r   <= cap_rs2_s;
            rs1_r       <= id_rs1;
            rs2_r       <= id_rs2;
            rd_r        <= id_rd;
            alu_op_r    <= id_alu_op;
            use_imm_r   <= id_use_imm;
            reg_write_r <= id_reg_write;
            mem_read_r  <= id_mem_read;
            mem_write_r <= id_mem_write;
        end else if (slot_valid_r && !advance_s) begin
            // Keep the stored operands current so a long stall never loses a write.
            if (src_match(memwb_reg_write, memwb_rd, rs1_r)) begin
                rs1_val_r <= memwb_result;
            end else begin
                rs1_val_r <= rs1_val_r;
            end
            if (src_match(memwb_reg_write, memwb_rd, rs2_r)) begin
                rs2_val_r <= memwb_result;
            end else begin
                rs2_val_r <= rs2_val_r;
            end
        end else begin
            rs1_val_r <= rs1_val_r;
            rs2_val_r <= rs2_val_r;
        end
    end

    // ---------------------------------------------------------------------
    // Execute-side outputs
    // ---------------------------------------------------------------------
    assign ex_op1        = rs1_res_s;
    assign ex_op2        = use_imm_r ? imm_r : rs2_res_s;
    assign ex_store_data = rs2_res_s;
    assign ex_pc         = pc_r;
    assign ex_alu_op     = alu_op_r;
    assign ex_rd         = rd_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_mem_write  = mem_write_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage
// ----------------------------------------------------------------------------
// Directed bench for id_ex_stage. Each issued instruction pushes its expected
// execute-side image into a queue; a monitor pops and compares whenever the
// stage hands an instruction to EX (ex_valid && ex_ready). Stall, flush and
// reset behaviour are checked directly by the stimulus thread. Expectations
// follow the ID_EX_FORWARDING_EN setting used to build the design.
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RIDX-1:0] id_rs1;
    logic [RIDX-1:0] id_rs2;
    logic [RIDX-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [3:0]      id_alu_op;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            flush;
    logic [RIDX-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic            exmem_mem_read;
    logic [XLEN-1:0] exmem_result;
    logic [RIDX-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [3:0]      ex_alu_op;
    logic [RIDX-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } tx_t;

    tx_t exp_q[$];
    tx_t mon_got;
    tx_t mon_exp;
    int  checks = 0;
    int  errors = 0;

    id_ex_stage #(.XLEN(XLEN), .RIDX(RIDX)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic ui, input logic [3:0] op,
                         input logic rw, input logic mr, input logic mw);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
        id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [31:0] sd, input logic [3:0] op, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
        tx_t t;
        t.pc = pc; t.op1 = op1; t.op2 = op2; t.sd = sd; t.op = op; t.rd = rd;
        t.rw = rw; t.mr = mr; t.mw = mw;
        exp_q.push_back(t);
    endtask

    task automatic producers_idle();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_result = 32'h0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'h0;
    endtask

    // Monitor: every instruction accepted by EX is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            mon_got.pc = ex_pc; mon_got.op1 = ex_op1; mon_got.op2 = ex_op2;
            mon_got.sd = ex_store_data; mon_got.op = ex_alu_op; mon_got.rd = ex_rd;
            mon_got.rw = ex_reg_write; mon_got.mr = ex_mem_read; mon_got.mw = ex_mem_write;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx got=%h exp=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_pc_%h got=%h exp=%h", mon_exp.pc, mon_got, mon_exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        drive(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        producers_idle();
        #2;
        // Reset state
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'h0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        #1 rst_n = 1'b1;
        step();

        // Plain instruction, no producers
        drive(32'h100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        push(32'h100, 32'h11, 32'h22, 32'h22, 4'h1, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        #1 chk("a_id_ready_on_advance", {31'd0, id_ready}, 32'd1);
        step();

        // Back-to-back issue: throughput of one per cycle, immediate operand
        drive(32'h200, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        push(32'h200, 32'h5, 32'h6, 32'h6, 4'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h204, 5'd4, 5'd5, 5'd6, 32'h7, 32'h99, 32'h5, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        push(32'h204, 32'h7, 32'h5, 32'h99, 4'h5, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("b_id_ready_b2b", {31'd0, id_ready}, 32'd1);
        step();
        id_valid = 1'b0;
        step();

        // Capture bypass from MEM/WB
        drive(32'h300, 5'd7, 5'd8, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
        memwb_rd = 5'd7; memwb_reg_write = 1'b1; memwb_result = 32'hABC;
        push(32'h300, 32'hABC, 32'h2, 32'h2, 4'h7, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        producers_idle();
        step();

        // EX/MEM producer on rs1 of sub x4,x3,x1
        drive(32'h400, 5'd3, 5'd1, 5'd4, 32'h30, 32'h8, 32'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h10;
`ifdef ID_EX_FORWARDING_EN
        push(32'h400, 32'h10, 32'h8, 32'h8, 4'h2, 5'd4, 1'b1, 1'b0, 1'b0);
        #1 chk("d_fwd_ex_valid", {31'd0, ex_valid}, 32'd1);
        step();
        producers_idle();
`else
        #1 chk("d_stall_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("d_stall_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        producers_idle();
        push(32'h400, 32'h30, 32'h8, 32'h8, 4'h2, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
`endif

        // Load-use on rs1 = x5, then MEM/WB delivers 0xDEAD
        drive(32'h500, 5'd5, 5'd6, 5'd8, 32'h50, 32'h60, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 32'hFFFF;
        #1 chk("e_lu_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("e_lu_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        producers_idle();
        memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'hDEAD;
`ifdef ID_EX_FORWARDING_EN
        push(32'h500, 32'hDEAD, 32'h60, 32'h60, 4'h3, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 chk("e_wb_fwd_ex_valid", {31'd0, ex_valid}, 32'd1);
        step();
        producers_idle();
`else
        #1 chk("e_wb_stall_ex_valid", {31'd0, ex_valid}, 32'd0);
        step();
        producers_idle();
        push(32'h500, 32'hDEAD, 32'h60, 32'h60, 4'h3, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
`endif

        // Backpressure with MEM/WB snoop of rs2 on a store
        drive(32'h600, 5'd9, 5'd10, 5'd11, 32'h90, 32'hA0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        memwb_rd = 5'd10; memwb_reg_write = 1'b1; memwb_result = 32'h77;
        step();
        producers_idle();
        step();
        #1 chk("f_snoop_store_data", ex_store_data, 32'h77);
        chk("f_snoop_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("f_bp_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        ex_ready = 1'b1;
        push(32'h600, 32'h90, 32'h77, 32'h77, 4'h0, 5'd11, 1'b0, 1'b0, 1'b1);
        step();

        // Flush colliding with an incoming instruction on an empty slot
        drive(32'hBAD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0;
        #1 chk("g_flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("g_flush_ex_pc", ex_pc, 32'h600);

        // Flush of a buffered instruction while another is offered
        drive(32'h700, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        step();
        ex_ready = 1'b0;
        drive(32'h704, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        #1 chk("g_kill_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("g_kill_ex_pc", ex_pc, 32'h700);
        step();

        // x0 source: producers targeting x0 neither forward nor stall
        drive(32'h800, 5'd0, 5'd2, 5'd1, 32'h0, 32'h3, 32'h0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h55;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h66;
        push(32'h800, 32'h0, 32'h3, 32'h3, 4'h6, 5'd1, 1'b1, 1'b0, 1'b0);
        #1 chk("h_x0_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("h_x0_ex_op1", ex_op1, 32'h0);
        step();
        producers_idle();

        // Reset asserted while the slot holds an instruction
        drive(32'h900, 5'd1, 5'd2, 5'd3, 32'h123, 32'h0, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        #1 chk("i_pre_rst_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("i_pre_rst_ex_op1", ex_op1, 32'h123);
        #1 rst_n = 1'b0;
        #1 chk("i_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("i_rst_ex_op1", ex_op1, 32'h0);
        chk("i_rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("i_rst_ex_pc", ex_pc, 32'h0);
        #1 rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        step();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
